// File: rtl/nand_logic_sequencer_pkg.sv
// nand_seq_pkg: opcodes, FSM states, step source/destination encodings and the per-op NAND step table
package nand_seq_pkg;
  localparam logic [2:0] OP_NAND    = 3'b000;
  localparam logic [2:0] OP_NOT     = 3'b001;
  localparam logic [2:0] OP_AND     = 3'b010;
  localparam logic [2:0] OP_OR      = 3'b011;
  localparam logic [2:0] OP_NOR     = 3'b100;
  localparam logic [2:0] OP_XOR     = 3'b101;
  localparam logic [2:0] OP_XNOR    = 3'b110;
  localparam logic [2:0] OP_ILLEGAL = 3'b111;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;
  typedef enum logic [2:0] {SRC_A, SRC_B, SRC_T1, SRC_T2, SRC_T3, SRC_Y} src_t;
  typedef enum logic [1:0] {DST_T1, DST_T2, DST_T3, DST_Y} dst_t;
  typedef struct packed {
    src_t x;
    src_t z;
    dst_t d;
  } step_t;
  // number of NAND evaluations each opcode needs
  function automatic logic [2:0] op_steps(input logic [2:0] op);
    logic [2:0] k;
    case (op)
      OP_NAND, OP_NOT: k = 3'd1;
      OP_AND:          k = 3'd2;
      OP_OR:           k = 3'd3;
      OP_NOR, OP_XOR:  k = 3'd4;
      OP_XNOR:         k = 3'd5;
      default:         k = 3'd0;
    endcase
    return k;
  endfunction
  // operand sources and destination for a given opcode and step index
  function automatic step_t step_lookup(input logic [2:0] op, input logic [2:0] step);
    step_t s;
    s = step_t'{SRC_A, SRC_B, DST_Y};
    case (op)
      OP_NOT: s = step_t'{SRC_A, SRC_A, DST_Y};
      OP_AND: s = (step == 3'd0) ? step_t'{SRC_A, SRC_B, DST_T1} : step_t'{SRC_T1, SRC_T1, DST_Y};
      OP_OR, OP_NOR:
        case (step)
          3'd0:    s = step_t'{SRC_A, SRC_A, DST_T1};
          3'd1:    s = step_t'{SRC_B, SRC_B, DST_T2};
          3'd2:    s = step_t'{SRC_T1, SRC_T2, DST_Y};
          default: s = step_t'{SRC_Y, SRC_Y, DST_Y};
        endcase
      OP_XOR, OP_XNOR:
        case (step)
          3'd0:    s = step_t'{SRC_A, SRC_B, DST_T1};
          3'd1:    s = step_t'{SRC_A, SRC_T1, DST_T2};
          3'd2:    s = step_t'{SRC_B, SRC_T1, DST_T3};
          3'd3:    s = step_t'{SRC_T2, SRC_T3, DST_Y};
          default: s = step_t'{SRC_Y, SRC_Y, DST_Y};
        endcase
      default: s = step_t'{SRC_A, SRC_B, DST_Y};
    endcase
    return s;
  endfunction
endpackage

// File: rtl/nand_logic_sequencer_nand_unit.sv
// nand_unit: the single shared combinational WIDTH-bit NAND
module nand_unit #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] z,
  output logic [WIDTH-1:0] y
);
  assign y = ~(x & z);
endmodule

// File: rtl/nand_logic_sequencer.sv
// nand_logic_sequencer: evaluates logic ops as NAND sequences on one shared NAND unit; optional NAND_SEQ_STATS_EN adds nand_count
module nand_logic_sequencer
  import nand_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             err,
  output logic             busy
`ifdef NAND_SEQ_STATS_EN
  ,
  output logic [15:0]      nand_count
`endif
);
  state_t           r_state, w_next;
  logic [2:0]       r_op, r_step;
  logic [WIDTH-1:0] r_a, r_b, r_t1, r_t2, r_t3, r_y;
  logic             r_err;
  logic             w_accept, w_last, w_exec;
  step_t            w_step;
  logic [WIDTH-1:0] w_x, w_z, w_n;
  function automatic logic [WIDTH-1:0] pick(input src_t s, input logic [WIDTH-1:0] sa, sb, s1, s2, s3, sy);
    return (s == SRC_A) ? sa : (s == SRC_B) ? sb : (s == SRC_T1) ? s1 :
           (s == SRC_T2) ? s2 : (s == SRC_T3) ? s3 : sy;
  endfunction
  assign w_accept = in_valid & in_ready;
  assign w_exec   = r_state == S_EXEC;
  assign w_last   = r_step == op_steps(r_op) - 3'd1;
  assign w_step   = step_lookup(r_op, r_step);
  assign w_x      = pick(w_step.x, r_a, r_b, r_t1, r_t2, r_t3, r_y);
  assign w_z      = pick(w_step.z, r_a, r_b, r_t1, r_t2, r_t3, r_y);
  nand_unit #(.WIDTH(WIDTH)) u_nand (.x(w_x), .z(w_z), .y(w_n));
  // state register
  always_ff @(posedge clk)
    if (rst) r_state <= S_IDLE;
    else r_state <= w_next;
  // next state: illegal ops skip EXEC, DONE waits for the consumer
  always_comb begin
    w_next = r_state;
    w_next = (r_state == S_IDLE) ? (w_accept ? ((op == OP_ILLEGAL) ? S_DONE : S_EXEC) : S_IDLE) :
             (r_state == S_EXEC) ? (w_last ? S_DONE : S_EXEC) :
             (out_ready ? S_IDLE : S_DONE);
  end
  // handshake and status outputs decoded from state
  always_comb begin
    in_ready  = r_state == S_IDLE;
    out_valid = r_state == S_DONE;
    busy      = r_state != S_IDLE;
  end
  // operand latch, step counter and one NAND write-back per EXEC cycle
  always_ff @(posedge clk)
    if (rst) begin
      r_op   <= '0;
      r_step <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_t1   <= '0;
      r_t2   <= '0;
      r_t3   <= '0;
      r_y    <= '0;
      r_err  <= 1'b0;
    end else if (w_accept) begin
      r_op   <= op;
      r_step <= '0;
      r_a    <= a;
      r_b    <= b;
      r_y    <= '0;
      r_err  <= op == OP_ILLEGAL;
    end else if (w_exec) begin
      r_step <= r_step + 3'd1;
      if (w_step.d == DST_T1) r_t1 <= w_n;
      if (w_step.d == DST_T2) r_t2 <= w_n;
      if (w_step.d == DST_T3) r_t3 <= w_n;
      if (w_step.d == DST_Y)  r_y  <= w_n;
    end
  assign y   = r_y;
  assign err = r_err;
`ifdef NAND_SEQ_STATS_EN
  logic [15:0] r_count;
  // saturating count of NAND evaluations
  always_ff @(posedge clk)
    if (rst) r_count <= '0;
    else if (w_exec && r_count != 16'hFFFF) r_count <= r_count + 16'd1;
  assign nand_count = r_count;
`endif
endmodule

// File: tb/tb_nand_logic_sequencer.sv
// tb_nand_logic_sequencer: scoreboard-driven self-checking bench for nand_logic_sequencer
module tb_nand_logic_sequencer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0, out_ready = 1'b0;
  logic       in_ready, out_valid, err, busy;
  logic [2:0] op = 3'd0;
  logic [3:0] a = 4'd0, b = 4'd0, y;
`ifdef NAND_SEQ_STATS_EN
  logic [15:0] nand_count;
  int          exp_count = 0;
`endif
  typedef struct {
    logic [3:0] y;
    logic       err;
    int         lat;
  } exp_t;
  exp_t q[$];
  int   n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  nand_logic_sequencer #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .err(err), .busy(busy)
`ifdef NAND_SEQ_STATS_EN
    , .nand_count(nand_count)
`endif
  );

  function automatic logic [3:0] model_y(input logic [2:0] o, input logic [3:0] x, input logic [3:0] z);
    case (o)
      3'd0: return ~(x & z);
      3'd1: return ~x;
      3'd2: return x & z;
      3'd3: return x | z;
      3'd4: return ~(x | z);
      3'd5: return x ^ z;
      3'd6: return ~(x ^ z);
      default: return 4'd0;
    endcase
  endfunction

  function automatic int model_k(input logic [2:0] o);
    case (o)
      3'd0, 3'd1: return 1;
      3'd2: return 2;
      3'd3: return 3;
      3'd4, 3'd5: return 4;
      3'd6: return 5;
      default: return 0;
    endcase
  endfunction

  // present one request, push its expectation; returns after the accept edge (+1)
  task automatic issue(input logic [2:0] o, input logic [3:0] x, input logic [3:0] z);
    exp_t e;
    e.y = model_y(o, x, z);
    e.err = (o == 3'd7);
    e.lat = model_k(o);
    q.push_back(e);
`ifdef NAND_SEQ_STATS_EN
    exp_count += model_k(o);
`endif
    in_valid = 1'b1; op = o; a = x; b = z;
    @(posedge clk); #1;
    in_valid = 1'b0; op = 3'($urandom); a = 4'($urandom); b = 4'($urandom);
  endtask

  // count cycles after the accept edge until out_valid, bounded
  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n_cmp++;
    if ({in_ready, out_valid, y, err, busy} !== {1'b1, 1'b0, 4'd0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset: rdy/vld/y/err/busy got %b%b %h %b%b want 10 0 00", in_ready, out_valid, y, err, busy);
    end
`ifdef NAND_SEQ_STATS_EN
    n_cmp++;
    if (nand_count !== 16'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", nand_count); end
`endif
  endtask

  // one op end to end: latency, result, error flag, then release
  task automatic test_op(input string nm, input logic [2:0] o, input logic [3:0] x, input logic [3:0] z);
    exp_t e;
    int lat;
    issue(o, x, z);
    n_cmp++;
    if (o != 3'd7 && busy !== 1'b1) begin n_bad++; $display("FAIL %s_busy: got %b want 1", nm, busy); end
    wait_done(lat);
    e = q.pop_front();
    n_cmp++;
    if (lat != e.lat) begin n_bad++; $display("FAIL %s_lat: got %0d want %0d", nm, lat, e.lat); end
    n_cmp++;
    if (y !== e.y || err !== e.err) begin
      n_bad++;
      $display("FAIL %s_result: y=%b err=%b want y=%b err=%b", nm, y, err, e.y, e.err);
    end
    handshake();
  endtask

  task automatic test_or();
    test_op("or", 3'd3, 4'b0101, 4'b0011);
  endtask

  task automatic test_xor_xnor();
    test_op("xor", 3'd5, 4'b0101, 4'b0011);
    test_op("xnor", 3'd6, 4'b0101, 4'b0011);
  endtask

  task automatic test_not_nand();
    test_op("not", 3'd1, 4'b1010, 4'b0000);
    test_op("nand", 3'd0, 4'b1100, 4'b1010);
  endtask

  task automatic test_backpressure();
    exp_t e;
    int lat;
    issue(3'd2, 4'b1111, 4'b0110);
    wait_done(lat);
    e = q.pop_front();
    n_cmp++;
    if (lat != e.lat || y !== e.y) begin n_bad++; $display("FAIL bp_first: lat=%0d y=%b want lat=%0d y=%b", lat, y, e.lat, e.y); end
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; op = 3'd0; a = 4'($urandom); b = 4'($urandom);
      @(posedge clk); #1;
      n_cmp++;
      if ({out_valid, in_ready, y, err} !== {1'b1, 1'b0, e.y, 1'b0}) begin
        n_bad++;
        $display("FAIL bp_hold%0d: vld=%b rdy=%b y=%b err=%b want 1 0 %b 0", i, out_valid, in_ready, y, err, e.y);
      end
    end
    in_valid = 1'b0;
    handshake();
    n_cmp++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      n_bad++;
      $display("FAIL bp_release: vld/rdy/busy got %b%b%b want 010", out_valid, in_ready, busy);
    end
  endtask

  task automatic test_illegal();
    test_op("illegal", 3'd7, 4'b1111, 4'b1111);
    test_op("after_illegal", 3'd2, 4'b1100, 4'b1010);
  endtask

  task automatic test_reset_mid();
    issue(3'd4, 4'b0101, 4'b0011);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    void'(q.pop_back());
`ifdef NAND_SEQ_STATS_EN
    exp_count = 0;
`endif
    n_cmp++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      n_bad++;
      $display("FAIL rstmid_state: vld/rdy/busy got %b%b%b want 010", out_valid, in_ready, busy);
    end
`ifdef NAND_SEQ_STATS_EN
    n_cmp++;
    if (nand_count !== 16'd0) begin n_bad++; $display("FAIL rstmid_count: got %0d want 0", nand_count); end
`endif
    repeat (5) @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_nopartial: vld=%b want 0", out_valid); end
    test_op("after_rst", 3'd4, 4'b0101, 4'b0011);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 24; i++) test_op("b2b", 3'(i % 8), 4'($urandom), 4'($urandom));
`ifdef NAND_SEQ_STATS_EN
    n_cmp++;
    if (nand_count !== 16'(exp_count)) begin n_bad++; $display("FAIL stats_count: got %0d want %0d", nand_count, exp_count); end
`endif
  endtask

  initial begin
    test_reset();
    test_or();
    test_xor_xnor();
    test_not_nand();
    test_backpressure();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
